// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encodings, lamp codes and service identifiers for the phase scheduler
package traffic_pkg;
  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    SIDE_G = 3'd2,
    SIDE_Y = 3'd3,
    WALK   = 3'd4
  } state_e;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b001;
  typedef enum logic {
    SERVE_WALK = 1'b0,
    SERVE_SIDE = 1'b1
  } serve_e;
  typedef struct packed {
    logic [2:0] main_l;
    logic [2:0] side_l;
    logic       walk_l;
  } lamps_t;
  function automatic lamps_t lamps_for(input state_e s);
    return s == MAIN_Y ? {LAMP_YELLOW, LAMP_RED, 1'b0} :
           s == SIDE_G ? {LAMP_RED, LAMP_GREEN, 1'b0} :
           s == SIDE_Y ? {LAMP_RED, LAMP_YELLOW, 1'b0} :
           s == WALK   ? {LAMP_RED, LAMP_RED, 1'b1} :
                         {LAMP_GREEN, LAMP_RED, 1'b0};
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: prescaler producing a one-cycle tick every TICK_DIV fast_clock cycles
module tick_divider #(
  parameter int TICK_DIV = 25000000
) (
  input  logic fast_clock,
  input  logic reset,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] presc_q, presc_d;
  assign tick = presc_q == W'(TICK_DIV - 1);
  assign presc_d = tick ? '0 : presc_q + W'(1);
  always_ff @(posedge fast_clock or negedge reset)
    if (!reset) presc_q <= '0;
    else presc_q <= presc_d;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: request latching, fair arbitration and phase sequencing for one intersection
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int MAIN_MIN = 6,
  parameter int SIDE_T   = 4,
  parameter int YELLOW_T = 2,
  parameter int WALK_T   = 3
) (
  input  logic       fast_clock,
  input  logic       reset,
  input  logic       walk_button,
  input  logic       side_sensor,
  output logic [2:0] main,
  output logic [2:0] side,
  output logic       walk_light,
  output logic       led_clock,
  output logic [4:0] counter
);
  logic       tick;
  logic [2:0] walk_sync_q;
  logic [1:0] side_sync_q;
  logic       walk_req_q, walk_req_d, side_req_q, side_req_d, led_q, led_d;
  logic       cnt_zero, phase_go, win_walk, enter_walk, enter_side;
  logic [4:0] cnt_q, cnt_d;
  state_e     state_q, state_d;
  serve_e     last_q, last_d;
  lamps_t     lamps_q, lamps_d;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .fast_clock(fast_clock),
    .reset     (reset),
    .tick      (tick)
  );

  function automatic logic [4:0] load_for(input state_e s);
    return s == MAIN_G ? 5'(MAIN_MIN - 1) :
           s == SIDE_G ? 5'(SIDE_T - 1) :
           s == WALK   ? 5'(WALK_T - 1) :
                         5'(YELLOW_T - 1);
  endfunction

  always_comb begin
    cnt_zero = cnt_q == 5'd0;
    phase_go = tick && cnt_zero;
    win_walk = walk_req_q && (!side_req_q || last_q == SERVE_SIDE);
    case (state_q)
      MAIN_G:  state_d = phase_go && (walk_req_q || side_req_q) ? MAIN_Y : MAIN_G;
      MAIN_Y:  state_d = !phase_go ? MAIN_Y : win_walk ? WALK : side_req_q ? SIDE_G : MAIN_G;
      SIDE_G:  state_d = phase_go ? SIDE_Y : SIDE_G;
      SIDE_Y:  state_d = phase_go ? MAIN_G : SIDE_Y;
      WALK:    state_d = phase_go ? MAIN_G : WALK;
      default: state_d = MAIN_G;
    endcase
    enter_walk = state_d == WALK && state_q != WALK;
    enter_side = state_d == SIDE_G && state_q != SIDE_G;
    cnt_d = state_d != state_q ? load_for(state_d) : (tick && !cnt_zero) ? cnt_q - 5'd1 : cnt_q;
    last_d = enter_walk ? SERVE_WALK : enter_side ? SERVE_SIDE : last_q;
    // Clearing on entry beats a same-cycle set; later sets wait for the next service.
    walk_req_d = enter_walk ? 1'b0 : walk_req_q | (walk_sync_q[1] & ~walk_sync_q[2]);
    side_req_d = enter_side ? 1'b0 : side_req_q | side_sync_q[1];
    led_d = led_q ^ tick;
    lamps_d = lamps_for(state_d);
  end

  always_ff @(posedge fast_clock or negedge reset)
    if (!reset) begin
      walk_sync_q <= '0;
      side_sync_q <= '0;
      walk_req_q  <= 1'b0;
      side_req_q  <= 1'b0;
      last_q      <= SERVE_SIDE;
      state_q     <= MAIN_G;
      cnt_q       <= 5'(MAIN_MIN - 1);
      led_q       <= 1'b0;
      lamps_q     <= {LAMP_GREEN, LAMP_RED, 1'b0};
    end else begin
      walk_sync_q <= {walk_sync_q[1:0], walk_button};
      side_sync_q <= {side_sync_q[0], side_sensor};
      walk_req_q  <= walk_req_d;
      side_req_q  <= side_req_d;
      last_q      <= last_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      led_q       <= led_d;
      lamps_q     <= lamps_d;
    end

  assign main       = lamps_q.main_l;
  assign side       = lamps_q.side_l;
  assign walk_light = lamps_q.walk_l;
  assign led_clock  = led_q;
  assign counter    = cnt_q;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: checkpoint-table scoreboard bench for the phase scheduler
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;
  logic       fast_clock = 1'b0, reset = 1'b0, walk_button = 1'b0, side_sensor = 1'b0;
  logic [2:0] main, side;
  logic       walk_light, led_clock;
  logic [4:0] counter;
  int tests = 0, fails = 0, tick_n = 0;

  typedef struct {
    int         sc;
    int         tk;
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
    logic [4:0] c;
  } exp_t;
  exp_t tbl[20];
  exp_t sb[$];

  always #5 fast_clock = ~fast_clock;

  traffic_phase_scheduler #(.TICK_DIV(4)) dut (
    .fast_clock (fast_clock),
    .reset      (reset),
    .walk_button(walk_button),
    .side_sensor(side_sensor),
    .main       (main),
    .side       (side),
    .walk_light (walk_light),
    .led_clock  (led_clock),
    .counter    (counter)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (tick %0d): got %0h want %0h", nm, tick_n, act, exp);
    end
  endtask

  always @(negedge fast_clock)
    chk("lamp_safety", 32'($onehot(main) && $onehot(side) && (main == LAMP_RED || side == LAMP_RED)), 32'd1);

  task automatic load_sc(input int sc);
    foreach (tbl[i]) if (tbl[i].sc == sc) sb.push_back(tbl[i]);
  endtask

  task automatic do_tick(input logic pw);
    exp_t e;
    walk_button = pw;
    @(negedge fast_clock);
    walk_button = 1'b0;
    repeat (3) @(negedge fast_clock);
    tick_n++;
    chk("led_clock", 32'(led_clock), 32'(tick_n % 2));
    while (sb.size() != 0 && sb[0].tk == tick_n) begin
      e = sb.pop_front();
      chk($sformatf("sc%0d_main", e.sc), 32'(main), 32'(e.m));
      chk($sformatf("sc%0d_side", e.sc), 32'(side), 32'(e.s));
      chk($sformatf("sc%0d_walk", e.sc), 32'(walk_light), 32'(e.w));
      chk($sformatf("sc%0d_counter", e.sc), 32'(counter), 32'(e.c));
    end
  endtask

  task automatic run_to(input int last, input int p1, input int p2);
    while (tick_n < last) do_tick(tick_n + 1 == p1 || tick_n + 1 == p2);
  endtask

  task automatic drain();
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    walk_button = 1'b0;
    side_sensor = 1'b0;
    repeat (2) @(negedge fast_clock);
    chk("rst_main", 32'(main), 32'(LAMP_GREEN));
    chk("rst_side", 32'(side), 32'(LAMP_RED));
    chk("rst_walk", 32'(walk_light), 32'd0);
    chk("rst_led", 32'(led_clock), 32'd0);
    chk("rst_counter", 32'(counter), 32'd5);
    reset = 1'b1;
    tick_n = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{2, 5, LAMP_GREEN, LAMP_RED, 1'b0, 5'd0};
    tbl[1]  = '{2, 6, LAMP_YELLOW, LAMP_RED, 1'b0, 5'd1};
    tbl[2]  = '{2, 7, LAMP_YELLOW, LAMP_RED, 1'b0, 5'd0};
    tbl[3]  = '{2, 8, LAMP_RED, LAMP_GREEN, 1'b0, 5'd3};
    tbl[4]  = '{2, 11, LAMP_RED, LAMP_GREEN, 1'b0, 5'd0};
    tbl[5]  = '{2, 12, LAMP_RED, LAMP_YELLOW, 1'b0, 5'd1};
    tbl[6]  = '{2, 14, LAMP_GREEN, LAMP_RED, 1'b0, 5'd5};
    tbl[7]  = '{3, 7, LAMP_YELLOW, LAMP_RED, 1'b0, 5'd0};
    tbl[8]  = '{3, 8, LAMP_RED, LAMP_RED, 1'b1, 5'd2};
    tbl[9]  = '{3, 10, LAMP_RED, LAMP_RED, 1'b1, 5'd0};
    tbl[10] = '{3, 11, LAMP_GREEN, LAMP_RED, 1'b0, 5'd5};
    tbl[11] = '{3, 16, LAMP_GREEN, LAMP_RED, 1'b0, 5'd0};
    tbl[12] = '{3, 17, LAMP_YELLOW, LAMP_RED, 1'b0, 5'd1};
    tbl[13] = '{3, 19, LAMP_RED, LAMP_RED, 1'b1, 5'd2};
    tbl[14] = '{4, 8, LAMP_RED, LAMP_RED, 1'b1, 5'd2};
    tbl[15] = '{4, 11, LAMP_GREEN, LAMP_RED, 1'b0, 5'd5};
    tbl[16] = '{4, 17, LAMP_YELLOW, LAMP_RED, 1'b0, 5'd1};
    tbl[17] = '{4, 19, LAMP_RED, LAMP_GREEN, 1'b0, 5'd3};
    tbl[18] = '{5, 5, LAMP_GREEN, LAMP_RED, 1'b0, 5'd0};
    tbl[19] = '{5, 7, LAMP_GREEN, LAMP_RED, 1'b0, 5'd0};

    do_reset();
    for (int n = 1; n <= 25; n++)
      sb.push_back('{1, n, LAMP_GREEN, LAMP_RED, 1'b0, n < 5 ? 5'(5 - n) : 5'd0});
    run_to(25, 0, 0);
    drain();

    do_reset();
    load_sc(2);
    do_tick(1'b0);
    side_sensor = 1'b1;
    run_to(14, 0, 0);
    drain();

    do_reset();
    load_sc(3);
    run_to(19, 3, 9);
    drain();

    do_reset();
    load_sc(4);
    side_sensor = 1'b1;
    run_to(19, 1, 9);
    drain();

    do_reset();
    side_sensor = 1'b1;
    run_to(9, 0, 0);
    chk("pre_rst_side", 32'(side), 32'(LAMP_GREEN));
    #2;
    reset = 1'b0;
    side_sensor = 1'b0;
    #1;
    chk("async_main", 32'(main), 32'(LAMP_GREEN));
    chk("async_side", 32'(side), 32'(LAMP_RED));
    chk("async_counter", 32'(counter), 32'd5);
    chk("async_walk", 32'(walk_light), 32'd0);
    @(negedge fast_clock);
    reset = 1'b1;
    tick_n = 0;
    load_sc(5);
    run_to(7, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
